// File: rtl/ps2_pkg.sv
// Shared PS/2 types: FSM states, frame length, parity helper.
// Used by ps2_host_tx and ps2_line_sync.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 3-flop synchroniser for one PS/2 line with edge pulses.
// Ports: clk, rst (sync, high), line (async in) -> level, rise, fall.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    // Idle bus is high; resetting to 1 avoids a false edge.
    always_ff @(posedge clk) begin
        if (rst) sync <= 3'b111;
        else     sync <= {sync[1:0], line};
    end

    assign level = sync[1];
    assign rise  = ~sync[2] & sync[1];
    assign fall  = sync[2] & ~sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, RTS, 11-bit frame, ACK).
// Ports: clk, rst, ps2_clk/ps2_data in, *_oe pull-downs, tx_data/tx_valid/
// tx_ready, done/ack_err/timeout status, rx_inhibit. Macro PS2_TX_TIMEOUT_EN
// enables the watchdog; without it timeout is tied to 0.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    output logic       rx_inhibit
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 2);

    ps2_state_t    state;
    logic [9:0]    shift;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;

    logic clk_lvl, clk_rise, clk_fall;
    logic data_lvl, data_rise, data_fall;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_clk),
        .level (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_data),
        .level (data_lvl),
        .rise  (data_rise),
        .fall  (data_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{clk_rise, data_rise, data_fall};

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_cnt;
    logic          wd_live;
    assign wd_live = (state == SEND) || (state == ACK)
                  || (state == WAIT_IDLE);
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            rx_inhibit  <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
`ifdef PS2_TX_TIMEOUT_EN
            timeout     <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            if (wd_live) wd_cnt <= clk_fall ? '0 : wd_cnt + WW'(1);
`endif
            unique case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift      <= {1'b1, odd_parity(tx_data), tx_data};
                        bit_cnt    <= '0;
                        inh_cnt    <= '0;
                        ack_err    <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        rx_inhibit <= 1'b1;
                        state      <= INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
                        timeout    <= 1'b0;
                        wd_cnt     <= '0;
`endif
                    end
                end
                INHIBIT: begin
                    // Our own clock pull-down shows up as a fall here; ignored.
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        state       <= SEND;
                    end else begin
                        inh_cnt <= inh_cnt + IW'(1);
                    end
                end
                SEND: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shift[0];
                        shift       <= {1'b0, shift[9:1]};
                        bit_cnt     <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) state <= ACK;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        ack_err <= data_lvl;
                        state   <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_lvl && data_lvl) begin
                        done       <= 1'b1;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Silent device: abandon the frame and release both lines.
            if (wd_live && !clk_fall && wd_cnt == WD_LAST) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                done        <= 1'b1;
                timeout     <= 1'b1;
                ack_err     <= 1'b1;
                tx_ready    <= 1'b1;
                rx_inhibit  <= 1'b0;
                state       <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Frames are checked against a byte->frame reference plus literal frames.
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int TMO = 2000;

    logic       clk;
    logic       rst;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, done, ack_err, timeout, rx_inhibit;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk, ps2_data;

    // Open-drain bus with pull-ups.
    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout),
        .rx_inhibit  (rx_inhibit)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: frame bits in wire order, {stop, odd parity, byte}.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    bit   mon_en = 0;
    bit   exp_busy = 0, prev_busy = 0, prev_done = 0;
    bit   pend_rst = 1, pend_cap = 0;
    int   oe_run = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic last_ack, last_tmo;
    logic [1:0] last_oe;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                prev_busy = exp_busy;
                if (pend_rst)           exp_busy = 0;
                else if (pend_cap)      exp_busy = 1;
                else if (done === 1'b1) exp_busy = 0;
                chk("tx_ready", tx_ready, !exp_busy);
                chk("rx_inhibit", rx_inhibit, exp_busy);
                chk("oe_excl", ps2_clk_oe & ps2_data_oe, 0);
                if (done === 1'b1) begin
                    chk("done_in_frame", prev_busy, 1);
                    chk("done_width", prev_done, 0);
                    done_cnt++;
                    done_cyc = cyc;
                    last_ack = ack_err;
                    last_tmo = timeout;
                    last_oe  = {ps2_clk_oe, ps2_data_oe};
                end
                if (ps2_clk_oe === 1'b1) begin
                    oe_run++;
                end else if (oe_run != 0) begin
                    chk("inhibit_len", oe_run, INH);
                    oe_run = 0;
                end
            end
            prev_done = (done === 1'b1);
            pend_rst  = rst;
            pend_cap  = tx_valid && (tx_ready === 1'b1) && !rst;
        end
    end

    // ---------------- device model ----------------
    int last_fall_cyc = 0;

    task automatic dev_frame(input int nclk, input bit ack,
                             input int half,
                             output logic [9:0] bits,
                             output bit rts_ok);
        int w;
        w = 0;
        bits = '0;
        rts_ok = 0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && w < 8000) begin
            wait_cyc(1);
            w++;
        end
        if (w >= 8000) return;
        rts_ok = 1;
        wait_cyc(half);
        for (int i = 0; i < nclk; i++) begin
            if (i == 10 && ack) begin
                dev_data_low = 1;
                wait_cyc(5);
            end
            dev_clk_low = 1;
            last_fall_cyc = cyc;
            wait_cyc(half);
            if (i < 10) bits[i] = ps2_data;
            dev_clk_low = 0;
            wait_cyc(half);
        end
        dev_data_low = 0;
    endtask

    task automatic request(input logic [7:0] b);
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < 1000) begin
            wait_cyc(1);
            w++;
        end
        chk("req_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1;
        wait_cyc(1);
        tx_valid = 0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_done(input string nm, input int d0);
        int w;
        w = 0;
        while (done_cnt == d0 && w < 3000) begin
            wait_cyc(1);
            w++;
        end
        chk({nm, "_done"}, done_cnt - d0, 1);
    endtask

    logic [9:0] got;
    bit         rts;

    task automatic do_frame(input string nm, input logic [7:0] b,
                            input bit ack, input int half,
                            input bit use_lit, input logic [9:0] lit);
        int d0;
        d0 = done_cnt;
        request(b);
        dev_frame(11, ack, half, got, rts);
        wait_done(nm, d0);
        chk({nm, "_rts"}, rts, 1);
        chk({nm, "_bits"}, got, frame_of(b));
        if (use_lit) chk({nm, "_lit"}, got, lit);
        chk({nm, "_ack_err"}, last_ack, !ack);
        chk({nm, "_timeout"}, last_tmo, 0);
        chk({nm, "_oe_rel"}, last_oe, 0);
    endtask

    // ---------------- stimulus ----------------
    int d0;

    initial begin
        rst = 1;
        tx_valid = 0;
        tx_data = 0;
        dev_clk_low = 0;
        dev_data_low = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rx_inhibit", rx_inhibit, 0);
        @(posedge clk);
        #1;
        rst = 0;
        mon_en = 1;
        wait_cyc(5);

        do_frame("ed", 8'hED, 1, 40, 1, 10'h3ED);
        do_frame("ff", 8'hFF, 1, 25, 1, 10'h3FF);
        do_frame("x01", 8'h01, 1, 25, 1, 10'h201);
        do_frame("nack", 8'h5A, 0, 25, 0, 10'h0);
        chk("nack_ready_after", tx_ready, 1);

        // Reset after the 4th data bit.
        d0 = done_cnt;
        request(8'h52);
        dev_frame(4, 0, 25, got, rts);
        chk("rst_mid_rts", rts, 1);
        chk("rst_mid_bits", got[3:0], 4'h2);
        chk("rst_mid_data_pull", ps2_data_oe, 1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        wait_cyc(1);
        rst = 0;
        wait_cyc(300);
        chk("rst_mid_no_done", done_cnt, d0);
        do_frame("f4", 8'hF4, 1, 25, 1, 10'h2F4);

        // tx_valid during SEND must be ignored.
        d0 = done_cnt;
        request(8'h3C);
        fork
            dev_frame(11, 1, 30, got, rts);
            begin
                wait_cyc(5300);
                chk("aa_busy", tx_ready, 0);
                tx_data  = 8'hAA;
                tx_valid = 1;
                wait_cyc(1);
                tx_valid = 0;
            end
        join
        wait_done("aa", d0);
        chk("aa_bits", got, 10'h33C);
        chk("aa_ack_err", last_ack, 0);
        wait_cyc(20);
        chk("aa_no_second", done_cnt, d0 + 1);
        chk("aa_idle_clk", ps2_clk_oe, 0);

        for (int k = 0; k < 3; k++) begin
            do_frame("rnd", 8'($urandom), 1'($urandom),
                     $urandom_range(20, 40), 0, 10'h0);
        end

`ifdef PS2_TX_TIMEOUT_EN
        d0 = done_cnt;
        request(8'h77);
        dev_frame(3, 0, 25, got, rts);
        wait_done("tmo", d0);
        chk("tmo_delay", done_cyc - last_fall_cyc, TMO + 3);
        chk("tmo_flag", last_tmo, 1);
        chk("tmo_ack_err", last_ack, 1);
        chk("tmo_oe", last_oe, 0);
        do_frame("post_tmo", 8'hED, 1, 25, 1, 10'h3ED);
`endif

        wait_cyc(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
